// File: rtl/jtag_dma_engine_if.sv
// Single-beat system-bus handshake between the JTAG DMA engine (master) and
// the bus fabric (slave).
interface jtag_dma_engine_if;
  logic        bus_request;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [3:0]  bus_byte_enable;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic        bus_ack;
  logic        bus_error;

  modport master (
    output bus_request, bus_write, bus_address, bus_byte_enable, bus_write_data,
    input  bus_read_data, bus_ack, bus_error
  );

  modport slave (
    input  bus_request, bus_write, bus_address, bus_byte_enable, bus_write_data,
    output bus_read_data, bus_ack, bus_error
  );
endinterface

// File: rtl/jtag_dma_engine.sv
// DMA side of the JTAG chain-1 datapath: moves whole bursts between its ping-pong
// buffer half and the system bus. Optional bus-wait abort via `DMA_TIMEOUT_EN.
module jtag_dma_engine #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        JTCK,
  input  logic        JRSTN,
  input  logic [31:0] dma_address,
  input  logic [3:0]  dma_byte_enable,
  input  logic        dma_data_ready,
  input  logic        dma_readReady,
  input  logic [7:0]  burst_size,
  output logic        switch_ready,
  output logic [8:0]  pp_address,
  output logic        pp_writeEnable,
  output logic [31:0] pp_dataIn,
  input  logic [31:0] pp_dataOut,
  output logic        bus_request,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byte_enable,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data,
  input  logic        bus_ack,
  input  logic        bus_error,
  output logic        dma_busy,
  output logic        dma_error,
  output logic [8:0]  words_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_FETCH,
    S_WR_LOAD,
    S_WR_BUS,
    S_RD_BUS,
    S_RD_STORE
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [7:0]  size_q;
  logic [7:0]  idx_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [8:0]  words_done_q;
  logic        req_q;
  logic        bus_write_q;
  logic        we_q;
  logic        switch_ready_q;
  logic        busy_q;
  logic        error_q;

  logic        last_word;
  logic        in_bus;
  logic        timeout_hit;
  logic        bus_fail;
  logic [7:0]  idx_d;
  logic [31:0] addr_d;
  logic [8:0]  words_done_d;

  assign last_word    = (idx_q == size_q);
  assign in_bus       = (state_q == S_WR_BUS) || (state_q == S_RD_BUS);
  assign idx_d        = idx_q + 8'd1;
  assign addr_d       = addr_q + 32'd4;
  assign words_done_d = words_done_q + 9'd1;

`ifdef DMA_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_q;

  // Counts stalled bus cycles; any cycle outside a bus state clears it, so
  // every entry to WR_BUS/RD_BUS starts from zero.
  assign timeout_hit = in_bus && !bus_ack && !bus_error &&
                       (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      wait_q <= '0;
    end else if (in_bus && !bus_ack && !bus_error) begin
      wait_q <= wait_q + WAIT_W'(1);
    end else begin
      wait_q <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // bus_error takes precedence over bus_ack in the same cycle.
  assign bus_fail = bus_error || timeout_hit;

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below reads the pre-edge value of each register regardless of ordering.
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      be_q           <= '0;
      size_q         <= '0;
      idx_q          <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      words_done_q   <= '0;
      req_q          <= 1'b0;
      bus_write_q    <= 1'b0;
      we_q           <= 1'b0;
      switch_ready_q <= 1'b1;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dma_data_ready || dma_readReady) begin
            addr_q         <= dma_address;
            be_q           <= dma_byte_enable;
            size_q         <= burst_size;
            idx_q          <= '0;
            words_done_q   <= '0;
            error_q        <= 1'b0;
            switch_ready_q <= 1'b0;
            busy_q         <= 1'b1;
            if (dma_data_ready) begin
              state_q <= S_WR_FETCH;
            end else begin
              state_q     <= S_RD_BUS;
              req_q       <= 1'b1;
              bus_write_q <= 1'b0;
            end
          end
        end

        // pp_address already carries the index; the buffer answers next cycle.
        S_WR_FETCH: begin
          state_q <= S_WR_LOAD;
        end

        S_WR_LOAD: begin
          wdata_q     <= pp_dataOut;
          req_q       <= 1'b1;
          bus_write_q <= 1'b1;
          state_q     <= S_WR_BUS;
        end

        S_WR_BUS: begin
          if (bus_fail) begin
            req_q          <= 1'b0;
            bus_write_q    <= 1'b0;
            error_q        <= 1'b1;
            switch_ready_q <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= S_IDLE;
          end else if (bus_ack) begin
            req_q        <= 1'b0;
            bus_write_q  <= 1'b0;
            words_done_q <= words_done_d;
            if (last_word) begin
              switch_ready_q <= 1'b1;
              busy_q         <= 1'b0;
              state_q        <= S_IDLE;
            end else begin
              idx_q   <= idx_d;
              addr_q  <= addr_d;
              state_q <= S_WR_FETCH;
            end
          end
        end

        S_RD_BUS: begin
          if (bus_fail) begin
            req_q          <= 1'b0;
            error_q        <= 1'b1;
            switch_ready_q <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= S_IDLE;
          end else if (bus_ack) begin
            rdata_q <= bus_read_data;
            req_q   <= 1'b0;
            we_q    <= 1'b1;
            state_q <= S_RD_STORE;
          end
        end

        // The buffer write strobe is high for exactly this state.
        S_RD_STORE: begin
          we_q         <= 1'b0;
          words_done_q <= words_done_d;
          if (last_word) begin
            switch_ready_q <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= S_IDLE;
          end else begin
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            req_q   <= 1'b1;
            state_q <= S_RD_BUS;
          end
        end

        default: begin
          req_q          <= 1'b0;
          bus_write_q    <= 1'b0;
          we_q           <= 1'b0;
          switch_ready_q <= 1'b1;
          busy_q         <= 1'b0;
          state_q        <= S_IDLE;
        end
      endcase
    end
  end

  // Only the lower buffer half is addressed; bit 8 belongs to the other side.
  assign pp_address      = {1'b0, idx_q};
  assign pp_writeEnable  = we_q;
  assign pp_dataIn       = rdata_q;
  assign switch_ready    = switch_ready_q;
  assign dma_busy        = busy_q;
  assign dma_error       = error_q;
  assign words_done      = words_done_q;

  assign bus_request     = req_q;
  assign bus_write       = bus_write_q;
  assign bus_address     = addr_q;
  assign bus_byte_enable = be_q;
  assign bus_write_data  = wdata_q;

endmodule

// File: doc/jtag_dma_engine.md
Name: jtag_dma_engine

Overview:
- Responder on the DMA side of the JTAG chain-1 datapath.
- Accepts the write-launch and read-launch pulses issued by the JTAG chain controller.
- Moves whole bursts between its half of the ping-pong buffer and the system bus via single-beat bus transfers.
- Reports buffer ownership back through switch_ready.

Parameters:
- TIMEOUT_CYCLES, 1023, cycles to wait for bus_ack/bus_error before abort (only with DMA_TIMEOUT_EN).

Ports:
- JTCK  in  1  clock; the single clock for the whole block.
- JRSTN  in  1  asynchronous active-low reset.
- dma_address  in  32  start byte address, sampled on a launch pulse.
- dma_byte_enable  in  4  byte lanes for every beat, sampled on a launch pulse.
- dma_data_ready  in  1  one-cycle write-launch pulse (buffer -> bus).
- dma_readReady  in  1  one-cycle read-launch pulse (bus -> buffer).
- burst_size  in  8  burst length minus one, sampled on a launch pulse.
- switch_ready  out  1  high when the engine does not own its buffer half.
- pp_address  out  9  DMA-side ping-pong word address.
- pp_writeEnable  out  1  DMA-side buffer write strobe.
- pp_dataIn  out  32  DMA-side buffer write data.
- pp_dataOut  in  32  DMA-side buffer read data, 1-cycle synchronous latency.
- bus_request  out  1  beat request; held until the beat ends.
- bus_write  out  1  1 = write beat, 0 = read beat.
- bus_address  out  32  beat byte address.
- bus_byte_enable  out  4  beat byte lanes.
- bus_write_data  out  32  write beat data.
- bus_read_data  in  32  read beat data, valid with bus_ack.
- bus_ack  in  1  one-cycle beat completion.
- bus_error  in  1  one-cycle beat failure; takes precedence over bus_ack.
- dma_busy  out  1  high whenever the state is not IDLE.
- dma_error  out  1  sticky error flag.
- words_done  out  9  beats completed in the current or last burst.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0 except switch_ready=1. Internal address, byte-enable, count and data registers also clear.
- Burst length is burst_size+1 words, range 1..256. Buffer words 0..burst_size are used. pp_address[8] is always 0.
- Bus address starts at dma_address and increments by 4 per beat, wrapping modulo 2^32.
- States: IDLE, WR_FETCH, WR_LOAD, WR_BUS, RD_BUS, RD_STORE.
- IDLE, launch handling:
  - On dma_data_ready: latch address, byte enable and size; clear words_done and dma_error; go to WR_FETCH.
  - On dma_readReady alone: same latching and clearing; go to RD_BUS.
  - Both pulses in the same cycle: the write wins and the read pulse is dropped.
  - Launch pulses arriving outside IDLE are ignored.
- Write path:
  - WR_FETCH: drive pp_address=word index for one cycle, then go to WR_LOAD.
  - WR_LOAD: capture pp_dataOut into the write-data register, then go to WR_BUS.
  - WR_BUS: bus_request=1, bus_write=1; address, byte enable and data held stable.
  - On bus_ack in WR_BUS: words_done+1. If that was the last word go to IDLE, else increment the index and go to WR_FETCH.
- Read path:
  - RD_BUS: bus_request=1, bus_write=0.
  - On bus_ack in RD_BUS: capture bus_read_data and go to RD_STORE.
  - RD_STORE: pp_writeEnable=1 for one cycle, with pp_address=index and pp_dataIn=captured data; words_done+1. If that was the last word go to IDLE, else go to RD_BUS.
- bus_request drops in the cycle after ack/error and is never asserted outside WR_BUS/RD_BUS.
- Latency per beat: write = 2 + bus wait cycles; read = bus wait + 1 cycles.
- bus_error in either bus state: dma_error=1, go to IDLE, remaining words abandoned, words_done holds the count already completed.
- switch_ready = (state==IDLE). It rises in the cycle after the final beat's ack (write) or the final RD_STORE (read).
- Reset mid-burst: immediate return to IDLE, with bus_request and pp_writeEnable deasserted asynchronously.

Optional Feature:
- DMA_TIMEOUT_EN defined:
  - A wait counter clears on entry to WR_BUS/RD_BUS and counts each cycle without ack or error.
  - When the counter reaches TIMEOUT_CYCLES: bus_request drops, dma_error=1, state goes to IDLE.
- DMA_TIMEOUT_EN undefined: no counter is instantiated; the engine waits indefinitely for bus_ack/bus_error.

Test Plan:
- Write burst: burst_size=3, dma_address=0x1000_0000, byte_enable=0xF, buffer holding 0xA0..0xA3 -> four write beats at 0x1000_0000/04/08/0C carrying 0xA0..0xA3; words_done=4; switch_ready returns to 1.
- Read burst: burst_size=1, address 0x2000_0010, bus returns 0x1111_1111 then 0x2222_2222 -> buffer words 0,1 written with those values; switch_ready low throughout, high after the second RD_STORE.
- Error: write burst_size=7 with bus_error on the third beat -> dma_error=1, words_done=2, IDLE; the next launch clears dma_error.
- Simultaneous launch: dma_data_ready and dma_readReady in the same cycle -> write path only; a dma_readReady pulse during WR_BUS is ignored.
- Wrap and reset: address 0xFFFF_FFFC with burst_size=1 -> second beat at 0x0000_0000; asserting JRSTN=0 during its bus wait -> bus_request=0 immediately, switch_ready=1.
- DMA_TIMEOUT_EN with TIMEOUT_CYCLES=15, bus never acks -> abort after 15 wait cycles with dma_error=1.
